nw_cell_engine: RTL and testbench

NW_CELL_ENGINE -- requirements
Module: nw_cell_engine

---
 rtl/nw_pkg.sv | 36 +++
 rtl/nw_max3.sv | 34 +++
 rtl/nw_cell_engine.sv | 156 +++++++++++++++
 tb/tb_nw_cell_engine.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nw_pkg.sv
// Shared definitions for the Needleman-Wunsch cell engine: score widths, default scoring,
// traceback codes, FSM encoding and the clamp used when NW_SATURATE_EN is defined.
package nw_pkg;

  localparam int SCORE_W      = 9;
  localparam int CALC_W       = SCORE_W + 1;

  localparam int DEF_MATCH    = 1;
  localparam int DEF_MISMATCH = -1;
  localparam int DEF_GAP      = -2;

  typedef logic signed [SCORE_W-1:0] score_t;
  typedef logic signed [CALC_W-1:0]  calc_t;
  typedef logic [1:0]                dir_t;

  localparam dir_t DIR_DIAG = 2'b00;
  localparam dir_t DIR_UP   = 2'b01;
  localparam dir_t DIR_LEFT = 2'b10;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_READ  = 3'd1;
  localparam logic [2:0] ST_CALC  = 3'd2;
  localparam logic [2:0] ST_WRITE = 3'd3;
  localparam logic [2:0] ST_NEXT  = 3'd4;
  localparam logic [2:0] ST_DONE  = 3'd5;

  localparam calc_t SAT_HI = 10'sd255;
  localparam calc_t SAT_LO = -10'sd256;

  function automatic calc_t sat_score(input calc_t v);
    if (v > SAT_HI) return SAT_HI;
    if (v < SAT_LO) return SAT_LO;
    return v;
  endfunction

endpackage

// File: rtl/nw_max3.sv
// Combinational three-way signed maximum; on equal values diag beats up beats left.
module nw_max3
  import nw_pkg::*;
#(
  parameter int W = CALC_W
) (
  input  logic signed [W-1:0] diag_i,
  input  logic signed [W-1:0] up_i,
  input  logic signed [W-1:0] left_i,
  output logic signed [W-1:0] max_o,
  output logic [1:0]          dir_o
);

  logic signed [W-1:0] best;
  logic [1:0]          best_dir;

  // strict '>' keeps the earlier candidate on a tie
  always_comb begin
    best     = diag_i;
    best_dir = DIR_DIAG;
    if (up_i > best) begin
      best     = up_i;
      best_dir = DIR_UP;
    end
    if (left_i > best) begin
      best     = left_i;
      best_dir = DIR_LEFT;
    end
  end

  assign max_o = best;
  assign dir_o = best_dir;

endmodule

// File: rtl/nw_cell_engine.sv
// Needleman-Wunsch matrix-fill sequencer: one cell per READ/CALC/WRITE/NEXT pass, row-major.
// Define NW_SATURATE_EN to clamp candidate scores to [-256,255] instead of wrapping to 9 bits.
module nw_cell_engine
  import nw_pkg::*;
#(
  parameter int N        = 128,
  parameter int BitAddr  = $clog2(N+1),
  parameter int MATCH    = DEF_MATCH,
  parameter int MISMATCH = DEF_MISMATCH,
  parameter int GAP      = DEF_GAP
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      start_i,
  input  logic [1:0]                char_a_i,
  input  logic [1:0]                char_b_i,
  input  logic                      ready_i,
  input  logic signed [SCORE_W-1:0] diag_i,
  input  logic signed [SCORE_W-1:0] up_i,
  input  logic signed [SCORE_W-1:0] left_i,
  output logic [BitAddr:0]          i_o,
  output logic [BitAddr:0]          j_o,
  output logic                      en_read_o,
  output logic                      en_ins_o,
  output logic                      we_o,
  output logic signed [SCORE_W-1:0] max_o,
  output logic [1:0]                dir_o,
  output logic                      busy_o,
  output logic                      done_o
);

  // states: IDLE wait start | READ fetch neighbours | CALC candidates | WRITE emit score | NEXT advance | DONE pulse
  localparam int AW = BitAddr + 1;
  localparam logic [AW-1:0] ONE  = AW'(1);
  localparam logic [AW-1:0] LAST = AW'(N);
  localparam calc_t MATCH_C    = calc_t'(MATCH);
  localparam calc_t MISMATCH_C = calc_t'(MISMATCH);
  localparam calc_t GAP_C      = calc_t'(GAP);

  logic [2:0]    state_q, state_d;
  logic [AW-1:0] i_q, i_d, j_q, j_d;
  score_t        diag_q, up_q, left_q;
  logic          match_q;
  calc_t         cd_q, cu_q, cl_q;
  calc_t         cd_raw, cu_raw, cl_raw, cd_d, cu_d, cl_d;
  score_t        max_q;
  dir_t          dir_q;
  calc_t         sel_val;
  logic [1:0]    sel_dir;
  score_t        sel_score;

  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d = ST_READ;
          i_d     = ONE;
          j_d     = ONE;
        end
      end
      ST_READ:  if (ready_i) state_d = ST_CALC;
      ST_CALC:  state_d = ST_WRITE;
      ST_WRITE: state_d = ST_NEXT;
      ST_NEXT: begin
        if (j_q < LAST) begin
          j_d     = j_q + ONE;
          state_d = ST_READ;
        end else if (i_q < LAST) begin
          j_d     = ONE;
          i_d     = i_q + ONE;
          state_d = ST_READ;
        end else begin
          state_d = ST_DONE;
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  assign cd_raw = calc_t'(diag_q) + (match_q ? MATCH_C : MISMATCH_C);
  assign cu_raw = calc_t'(up_q) + GAP_C;
  assign cl_raw = calc_t'(left_q) + GAP_C;

`ifdef NW_SATURATE_EN
  assign cd_d = sat_score(cd_raw);
  assign cu_d = sat_score(cu_raw);
  assign cl_d = sat_score(cl_raw);
`else
  assign cd_d = cd_raw;
  assign cu_d = cu_raw;
  assign cl_d = cl_raw;
`endif

  nw_max3 #(.W(CALC_W)) u_max3 (
    .diag_i (cd_q),
    .up_i   (cu_q),
    .left_i (cl_q),
    .max_o  (sel_val),
    .dir_o  (sel_dir)
  );

  assign sel_score = score_t'(sel_val);

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q <= ST_IDLE;
      i_q     <= ONE;
      j_q     <= ONE;
      diag_q  <= '0;
      up_q    <= '0;
      left_q  <= '0;
      match_q <= 1'b0;
      cd_q    <= '0;
      cu_q    <= '0;
      cl_q    <= '0;
      max_q   <= '0;
      dir_q   <= DIR_DIAG;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      if (state_q == ST_READ && ready_i) begin
        diag_q  <= diag_i;
        up_q    <= up_i;
        left_q  <= left_i;
        match_q <= (char_a_i == char_b_i);
      end
      if (state_q == ST_CALC) begin
        cd_q <= cd_d;
        cu_q <= cu_d;
        cl_q <= cl_d;
      end
      if (state_q == ST_WRITE) begin
        max_q <= sel_score;
        dir_q <= sel_dir;
      end
    end
  end

  // strobes are gated by reset so a reset landing on WRITE emits no write
  assign en_read_o = (state_q == ST_READ);
  assign en_ins_o  = (state_q == ST_WRITE) && rst_i;
  assign we_o      = en_ins_o;
  assign max_o     = (state_q == ST_WRITE) ? sel_score : max_q;
  assign dir_o     = (state_q == ST_WRITE) ? sel_dir : dir_q;
  assign busy_o    = (state_q == ST_READ) || (state_q == ST_CALC) ||
                     (state_q == ST_WRITE) || (state_q == ST_NEXT);
  assign done_o    = (state_q == ST_DONE);
  assign i_o       = i_q;
  assign j_o       = j_q;

endmodule

// File: tb/tb_nw_cell_engine.sv
// Bench for nw_cell_engine (N=4): directed fills, a score model and a per-cycle write checker.
module tb_nw_cell_engine;

  localparam int N     = 4;
  localparam int AW    = $clog2(N+1) + 1;
  localparam int CELLS = N * N;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst, start, ready;
  logic [1:0]        ca, cb;
  logic signed [8:0] diag, up, left;
  logic [AW-1:0]     i_w, j_w;
  logic              en_read_w, en_ins_w, we_w, busy_w, done_w;
  logic signed [8:0] max_w;
  logic [1:0]        dir_w;

  nw_cell_engine #(.N(N)) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .start_i   (start),
    .char_a_i  (ca),
    .char_b_i  (cb),
    .ready_i   (ready),
    .diag_i    (diag),
    .up_i      (up),
    .left_i    (left),
    .i_o       (i_w),
    .j_o       (j_w),
    .en_read_o (en_read_w),
    .en_ins_o  (en_ins_w),
    .we_o      (we_w),
    .max_o     (max_w),
    .dir_o     (dir_w),
    .busy_o    (busy_w),
    .done_o    (done_w)
  );

  typedef struct {
    int i; int j; int mx; int dr;
    bit lit; int lmx; int ldr;
  } exp_t;

  exp_t expq[$];
  exp_t e;
  int   errors = 0, checks = 0;
  int   cyc = 0, rst_edges = 0, seen_rst = 0;
  int   wr_cnt = 0, gap_exp = 4, last_cyc = 0;
  bit   have_last = 0;
  int   held_max = 0, held_dir = 0;

  int td[CELLS], tu[CELLS], tl[CELLS], tca[CELLS], tcb[CELLS];
  bit tlit[CELLS];
  int tlmx[CELLS], tldr[CELLS];

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (!rst) rst_edges <= rst_edges + 1;

  task automatic chk(input string name, input int act, input int exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  function automatic int wrap9(input int v);
    int r;
    r = v % 512;
    if (r < 0) r += 512;
    if (r >= 256) r -= 512;
    return r;
  endfunction

  // score of one cell from the recurrence: best of three candidates, first one wins ties
  function automatic void model_cell(input int d, input int u, input int l, input bit m,
                                     output int mx, output int dr);
    int s[3];
    s[0] = d + (m ? 1 : -1);
    s[1] = u - 2;
    s[2] = l - 2;
`ifdef NW_SATURATE_EN
    for (int k = 0; k < 3; k++) begin
      if (s[k] > 255) s[k] = 255;
      if (s[k] < -256) s[k] = -256;
    end
`endif
    dr = 0;
    for (int k = 1; k < 3; k++) if (s[k] > s[dr]) dr = k;
    mx = wrap9(s[dr]);
  endfunction

  task automatic fill_random();
    for (int c = 0; c < CELLS; c++) begin
      td[c]   = int'($urandom_range(0, 511)) - 256;
      tu[c]   = int'($urandom_range(0, 511)) - 256;
      tl[c]   = int'($urandom_range(0, 511)) - 256;
      tca[c]  = int'($urandom_range(0, 3));
      tcb[c]  = int'($urandom_range(0, 3));
      tlit[c] = 1'b0;
      tlmx[c] = 0;
      tldr[c] = 0;
    end
  endtask

  task automatic set_cell(input int c, input int a, input int b, input int d, input int u,
                          input int l, input int lmx, input int ldr);
    tca[c] = a; tcb[c] = b; td[c] = d; tu[c] = u; tl[c] = l;
    tlit[c] = 1'b1; tlmx[c] = lmx; tldr[c] = ldr;
  endtask

  task automatic fill_directed();
    fill_random();
    set_cell(0, 2, 2, 0, -1, -1, 1, 0);
    set_cell(1, 0, 1, 1, 2, -5, 0, 0);
    set_cell(2, 0, 1, -3, 0, 0, -2, 1);
`ifdef NW_SATURATE_EN
    set_cell(3, 1, 1, 255, 0, 0, 255, 0);
    set_cell(6, 1, 2, -256, -256, -256, -256, 0);
`else
    set_cell(3, 1, 1, 255, 0, 0, -256, 0);
    set_cell(6, 1, 2, -256, -256, -256, 255, 0);
`endif
    set_cell(4, 0, 3, -10, -10, 5, 3, 2);
    set_cell(5, 0, 3, -10, 4, 4, 2, 1);
  endtask

  task automatic wait_read(output bit ok);
    ok = en_read_w;
    for (int k = 0; k < 20 && !ok; k++) begin
      @(posedge clk); #1;
      ok = en_read_w;
    end
    chk("en_read_seen", int'(ok), 1);
  endtask

  task automatic reset_values(input string tag);
    chk({tag, "_i"}, int'(i_w), 1);
    chk({tag, "_j"}, int'(j_w), 1);
    chk({tag, "_en_read"}, int'(en_read_w), 0);
    chk({tag, "_en_ins"}, int'(en_ins_w), 0);
    chk({tag, "_we"}, int'(we_w), 0);
    chk({tag, "_max"}, int'(max_w), 0);
    chk({tag, "_dir"}, int'(dir_w), 0);
    chk({tag, "_busy"}, int'(busy_w), 0);
    chk({tag, "_done"}, int'(done_w), 0);
  endtask

  task automatic do_fill(input int delay, input bit disturb, input int reset_at);
    bit ok;
    int mx, dr;
    wr_cnt    = 0;
    have_last = 0;
    gap_exp   = delay + 4;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 0; c < CELLS; c++) begin
      wait_read(ok);
      if (!ok) return;
      if (c == 0) chk("busy_in_fill", int'(busy_w), 1);
      if (c == reset_at) begin
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_values("midfill_rst");
        chk("queue_empty_at_reset", expq.size(), 0);
        rst = 1'b1;
        return;
      end
      repeat (delay) begin
        @(posedge clk); #1;
        chk("en_read_held", int'(en_read_w), 1);
      end
      ca   = 2'(tca[c]);
      cb   = 2'(tcb[c]);
      diag = 9'(td[c]);
      up   = 9'(tu[c]);
      left = 9'(tl[c]);
      model_cell(td[c], tu[c], tl[c], tca[c] == tcb[c], mx, dr);
      expq.push_back('{i: c / N + 1, j: c % N + 1, mx: mx, dr: dr,
                       lit: tlit[c], lmx: tlmx[c], ldr: tldr[c]});
      ready = 1'b1;
      @(posedge clk); #1;
      ready = 1'b0;
      diag  = 9'($urandom_range(0, 511));
      up    = 9'($urandom_range(0, 511));
      left  = 9'($urandom_range(0, 511));
      ca    = 2'($urandom_range(0, 3));
      cb    = 2'($urandom_range(0, 3));
      chk("en_read_drop", int'(en_read_w), 0);
      if (disturb && (c % 5 == 3)) begin
        ready = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        ready = 1'b0;
        start = 1'b0;
      end
    end
    ok = 1'b0;
    for (int k = 0; k < 20 && !ok; k++) begin
      @(posedge clk); #1;
      if (done_w) ok = 1'b1;
    end
    chk("done_seen", int'(ok), 1);
    if (ok) begin
      chk("busy_at_done", int'(busy_w), 0);
      chk("i_at_done", int'(i_w), N);
      chk("j_at_done", int'(j_w), N);
      chk("write_count", wr_cnt, CELLS);
      @(posedge clk); #1;
      chk("done_one_cycle", int'(done_w), 0);
      chk("busy_idle", int'(busy_w), 0);
      chk("i_hold", int'(i_w), N);
      chk("j_hold", int'(j_w), N);
    end
    chk("queue_empty", expq.size(), 0);
  endtask

  // write checker: every write matches the next expected cell, and scores hold between writes
  initial begin
    forever begin
      @(negedge clk);
      if (rst_edges != seen_rst) begin
        held_max = 0;
        held_dir = 0;
        seen_rst = rst_edges;
      end
      chk("ins_eq_we", int'(en_ins_w), int'(we_w));
      if (we_w) begin
        wr_cnt++;
        chk("write_expected", int'(expq.size() > 0), 1);
        if (expq.size() > 0) begin
          e = expq.pop_front();
          chk("wr_i", int'(i_w), e.i);
          chk("wr_j", int'(j_w), e.j);
          chk("wr_max", int'(max_w), e.mx);
          chk("wr_dir", int'(dir_w), e.dr);
          if (e.lit) begin
            chk("lit_max", int'(max_w), e.lmx);
            chk("lit_dir", int'(dir_w), e.ldr);
          end
          if (have_last) chk("write_gap", cyc - last_cyc, gap_exp);
          have_last = 1'b1;
          last_cyc  = cyc;
          held_max  = e.mx;
          held_dir  = e.dr;
        end
      end else begin
        chk("max_hold", int'(max_w), held_max);
        chk("dir_hold", int'(dir_w), held_dir);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

  initial begin
    rst   = 1'b0;
    start = 1'b0;
    ready = 1'b0;
    ca    = 2'd0;
    cb    = 2'd0;
    diag  = '0;
    up    = '0;
    left  = '0;
    repeat (3) @(posedge clk);
    #1;
    reset_values("init_rst");
    rst = 1'b1;
    @(posedge clk); #1;

    fill_directed();
    do_fill(2, 1'b1, -1);

    fill_random();
    do_fill(0, 1'b0, -1);

    fill_random();
    do_fill(1, 1'b1, 5);
    repeat (2) @(posedge clk);
    #1;
    chk("post_rst_idle_i", int'(i_w), 1);
    chk("post_rst_idle_busy", int'(busy_w), 0);

    fill_random();
    do_fill(0, 1'b1, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
